// File: rtl/uart_pkg.sv
// Shared constants for the arbitrated UART transmitter: FSM state encodings,
// data width, line levels and the even-parity helper.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned ST_W           = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_START  = 3'd1;
  localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
  localparam logic [ST_W-1:0] ST_PARITY = 3'd3;
  localparam logic [ST_W-1:0] ST_STOP   = 3'd4;

  localparam logic START_BIT_LEVEL = 1'b0;
  localparam logic STOP_BIT_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL      = 1'b1;

  // Even parity over one data byte (XOR of all data bits).
  function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_baud_tick.sv
// Bit-period timer: o_tick pulses for one cycle every CLKS_PER_BIT cycles,
// counting restarts from zero on i_clr so a frame starts phase-aligned.
module baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 312
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt_c;

  // Next count: clear on request, wrap at the last cycle of the bit period.
  always_comb begin
    cnt_nxt_c = cnt + CNT_W'(1);
    if (i_clr || (cnt == CNT_MAX)) begin
      cnt_nxt_c = '0;
    end
  end

  // Counter and registered tick, high while the counter sits at CNT_MAX.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else begin
      cnt    <= cnt_nxt_c;
      o_tick <= (cnt_nxt_c == CNT_MAX);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbitrated UART transmitter: one byte per grant from N_REQ
// producers, serialised 8N1 (or 8E1 when UART_TX_PARITY_EN is defined).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned CLKS_PER_BIT = 312
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [8*N_REQ-1:0]       i_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_busy,
  output logic                     o_tx
);

  localparam int unsigned ID_W = $clog2(N_REQ);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic [ST_W-1:0]           state,      state_nxt;
  logic [UART_DATA_BITS-1:0] shift,      shift_nxt;
  logic [2:0]                bit_cnt,    bit_cnt_nxt;
  logic [ID_W-1:0]           last_grant, last_grant_nxt;
  logic [ID_W-1:0]           grant_nxt;
  logic [N_REQ-1:0]          ack_nxt;
  logic                      busy_nxt;
  logic                      tx_nxt;
`ifdef UART_TX_PARITY_EN
  logic                      parity_bit, parity_bit_nxt;
`endif

  logic                      rr_found_c;
  logic [ID_W-1:0]           rr_idx_c;
  logic [UART_DATA_BITS-1:0] rr_byte_c;
  logic                      baud_clr_c;
  logic                      tick;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (baud_clr_c),
    .o_tick (tick)
  );

  // Round-robin search starting one past the last grant, wrapping modulo N_REQ.
  always_comb begin
    rr_found_c = 1'b0;
    rr_idx_c   = last_grant;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      if (!rr_found_c && i_req[(int'(last_grant) + i) % int'(N_REQ)]) begin
        rr_found_c = 1'b1;
        rr_idx_c   = ID_W'((int'(last_grant) + i) % int'(N_REQ));
      end
    end
    rr_byte_c = i_data[{rr_idx_c, 3'b000} +: UART_DATA_BITS];
  end

  // Frame sequencing: grant in IDLE, then start, data, optional parity, stop.
  always_comb begin
    state_nxt      = state;
    shift_nxt      = shift;
    bit_cnt_nxt    = bit_cnt;
    last_grant_nxt = last_grant;
    grant_nxt      = o_grant_id;
    ack_nxt        = '0;
    busy_nxt       = o_busy;
    tx_nxt         = o_tx;
    baud_clr_c     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_bit_nxt = parity_bit;
`endif

    case (state)
      ST_IDLE: begin
        tx_nxt   = IDLE_LEVEL;
        busy_nxt = 1'b0;
        if (rr_found_c) begin
          state_nxt      = ST_START;
          tx_nxt         = START_BIT_LEVEL;
          busy_nxt       = 1'b1;
          ack_nxt        = N_REQ'(1) << rr_idx_c;
          grant_nxt      = rr_idx_c;
          last_grant_nxt = rr_idx_c;
          shift_nxt      = rr_byte_c;
          bit_cnt_nxt    = '0;
          baud_clr_c     = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_bit_nxt = calc_parity(rr_byte_c);
`endif
        end
      end

      ST_START: begin
        if (tick) begin
          state_nxt = ST_DATA;
          tx_nxt    = shift[0];
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = ST_PARITY;
            tx_nxt    = parity_bit;
`else
            state_nxt = ST_STOP;
            tx_nxt    = STOP_BIT_LEVEL;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            shift_nxt   = {1'b0, shift[UART_DATA_BITS-1:1]};
            tx_nxt      = shift[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_nxt = ST_STOP;
          tx_nxt    = STOP_BIT_LEVEL;
        end
      end
`endif

      ST_STOP: begin
        if (tick) begin
          state_nxt   = ST_IDLE;
          tx_nxt      = IDLE_LEVEL;
          busy_nxt    = 1'b0;
          bit_cnt_nxt = '0;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        tx_nxt    = IDLE_LEVEL;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any frame with the line idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      o_grant_id <= '0;
      o_ack      <= '0;
      o_busy     <= 1'b0;
      o_tx       <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      shift      <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      last_grant <= last_grant_nxt;
      o_grant_id <= grant_nxt;
      o_ack      <= ack_nxt;
      o_busy     <= busy_nxt;
      o_tx       <= tx_nxt;
`ifdef UART_TX_PARITY_EN
      parity_bit <= parity_bit_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with N_REQ=4, CLKS_PER_BIT=4.
// Honours UART_TX_PARITY_EN for frame length and the parity case.
module tb_uart_tx_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned CPB   = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11 * CPB;
`else
  localparam int FL = 10 * CPB;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req   = '0;
  logic [31:0] data  = 32'h4433_2211;
  logic [3:0]  ack;
  logic [1:0]  gid;
  logic        busy;
  logic        tx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  uart_tx_arbiter #(
    .N_REQ       (N_REQ),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_data    (data),
    .o_ack     (ack),
    .o_grant_id(gid),
    .o_busy    (busy),
    .o_tx      (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected line level per cycle of a frame (bit 0 = first start-bit cycle).
  function automatic logic [63:0] exp_wave(input logic [7:0] b);
    logic [63:0] w;
    int k;
    w = '0;
    for (int o = 0; o < FL; o++) begin
      k = o / int'(CPB);
      if (k == 0)      w[o] = 1'b0;
      else if (k <= 8) w[o] = b[k-1];
`ifdef UART_TX_PARITY_EN
      else if (k == 9) w[o] = ^b;
`endif
      else             w[o] = 1'b1;
    end
    return w;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Wait for an ack pulse; returns requester index and cycle stamp.
  task automatic wait_grant(input string tag, output int id, output int t);
    id = -1;
    t  = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ack != 4'b0000) begin
        t = cyc;
        for (int k = 0; k < 4; k++) if (ack[k]) id = k;
        break;
      end
    end
    if (id < 0) check({tag, "_grant_timeout"}, 64'(1), 64'(0));
  endtask

  // Capture one frame starting at the grant sample; optionally pulse a
  // request mid-frame and withdraw it before the frame ends.
  task automatic rx_frame(input logic [7:0] b, input string tag, input logic [3:0] wd_mask);
    logic [63:0] w;
    int busy_n;
    int ack_late;
    w = '0;
    busy_n = 0;
    ack_late = 0;
    for (int o = 0; o < FL; o++) begin
      if (o > 0) @(negedge clk);
      w[o] = tx;
      if (busy) busy_n++;
      if (o > 0 && ack != 4'b0000) ack_late++;
      if (o == 10) req = req | wd_mask;
      if (o == 30) req = req & ~wd_mask;
    end
    check({tag, "_wave"}, w, exp_wave(b));
    check({tag, "_busy_len"}, 64'(busy_n), 64'(FL));
    check({tag, "_ack_len"}, 64'(ack_late), 64'(0));
    @(negedge clk);
    check({tag, "_idle"}, 64'({busy, tx}), 64'(2'b01));
  endtask

  initial begin
    int id;
    int t;
    int tp;
    int t0;
    int acks;
    int busies;

    do_reset();
    check("rst_tx",   64'(tx),   64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ack",  64'(ack),  64'(0));
    check("rst_gid",  64'(gid),  64'(0));

    // Single byte from requester 2
    data[23:16] = 8'hA5;
    req = 4'b0100;
    t0  = cyc;
    wait_grant("t1", id, t);
    check("t1_ack", 64'(ack), 64'(4'b0100));
    check("t1_gid", 64'(gid), 64'(2));
    check("t1_latency", 64'(t - t0), 64'(1));
    req = '0;
    rx_frame(8'hA5, "t1", 4'b0000);

    // All four requesting from reset
    do_reset();
    data = 32'h4433_2211;
    req  = 4'b1111;
    tp   = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant("t2", id, t);
      check("t2_id",  64'(id),  64'(k));
      check("t2_gid", 64'(gid), 64'(k));
      if (k > 0) check("t2_gap", 64'(t - tp), 64'(FL + 1));
      tp = t;
      if (id >= 0) req[id] = 1'b0;
      rx_frame(data[8*k +: 8], "t2", 4'b0000);
    end

    // Round-robin after a grant to 1, then withdrawal of 1 during a frame
    do_reset();
    req = 4'b0010;
    wait_grant("t3", id, t);
    check("t3_first", 64'(id), 64'(1));
    req = 4'b1001;
    rx_frame(8'h22, "t3a", 4'b0000);
    wait_grant("t3", id, t);
    check("t3_second", 64'(id), 64'(3));
    req[3] = 1'b0;
    rx_frame(8'h44, "t3b", 4'b0000);
    wait_grant("t3", id, t);
    check("t3_third", 64'(id), 64'(0));
    req[0] = 1'b0;
    rx_frame(8'h11, "t4", 4'b0010);
    acks = 0;
    busies = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ack != 4'b0000) acks++;
      if (busy) busies++;
    end
    check("t4_no_ack",   64'(acks),   64'(0));
    check("t4_no_frame", 64'(busies), 64'(0));

    // Reset in the middle of data bit 3
    do_reset();
    req = 4'b0100;
    wait_grant("t5", id, t);
    req = '0;
    for (int o = 1; o < 18; o++) @(negedge clk);
    check("t5_pre_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx",   64'(tx),   64'(1));
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_gid",  64'(gid),  64'(0));
    acks = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (ack != 4'b0000) acks++;
    end
    check("t5_no_ack", 64'(acks), 64'(0));
    rst_n = 1'b1;
    req = 4'b1111;
    wait_grant("t5", id, t);
    check("t5_prio0", 64'(id), 64'(0));
    req = '0;
    rx_frame(8'h11, "t5", 4'b0000);

`ifdef UART_TX_PARITY_EN
    // Parity bit for 0x07
    do_reset();
    data[7:0] = 8'h07;
    req = 4'b0001;
    wait_grant("t6", id, t);
    check("t6_id", 64'(id), 64'(0));
    req = '0;
    rx_frame(8'h07, "t6", 4'b0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one 8N1 UART transmitter among `N_REQ` byte producers on the 3 MHz system clock. A round-robin arbiter grants the line one byte at a time. The block serializes each byte at a bit rate set by an internal baud-tick counter. It replaces free-running divided baud clocks with a single-clock, enable-based design that sits between the logic modules and the board TX pin.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; must be ≥ 2.
- `CLKS_PER_BIT`, default 312: `i_clk` cycles per bit (3 MHz / 312 ≈ 9615 baud); must be ≥ 2.

Ports:
- `i_clk`, in, 1: system clock, 3 MHz. This is the block's only clock.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_req`, in, `N_REQ`: bit k high means requester k has a byte pending.
- `i_data`, in, `8*N_REQ`: requester k's byte is on `i_data[8k+7:8k]`.
- `o_ack`, out, `N_REQ`: one-cycle pulse to the requester whose byte was latched.
- `o_grant_id`, out, `$clog2(N_REQ)`: index of the requester that owns the current frame.
- `o_busy`, out, 1: high while a frame is in progress.
- `o_tx`, out, 1: serial line; idles high.

## Operation
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- **IDLE:** `o_tx`=1 and `o_busy`=0. On any edge where `i_req`≠0, the arbiter grants one requester:
  - Search starts at `last_grant+1` and wraps modulo `N_REQ`.
  - The granted requester's byte is latched into the shift register.
  - `last_grant` and `o_grant_id` update.
  - The FSM moves to START.
- **START:** `o_tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- **DATA:** 8 bits, LSB first, each held `CLKS_PER_BIT` cycles.
  - A 3-bit counter tracks the bits.
  - After bit 7 the FSM goes to PARITY or STOP.
- **STOP:** `o_tx`=1 for `CLKS_PER_BIT` cycles, then IDLE.
- **Handshake:**
  - A requester holds `i_req` high and `i_data` stable until it sees `o_ack`.
  - Data is sampled only at the grant edge.
  - Dropping `i_req` before the grant withdraws the request silently.
  - `i_req` held high after `o_ack` counts as a new pending byte.
- **Baud counter:**
  - Width is `$clog2(CLKS_PER_BIT)`.
  - It is cleared at the grant edge, so the start bit lasts exactly `CLKS_PER_BIT` cycles.
  - It wraps at `CLKS_PER_BIT-1`, where it issues a one-cycle tick that advances the FSM.
- **Grant scope:** `i_req` changes during a frame do not affect that frame. Arbitration happens only in IDLE.

## Timing
- **Reset values:**
  - `o_tx`=1, `o_busy`=0, `o_ack`=0, `o_grant_id`=0.
  - `last_grant`=`N_REQ-1`, so requester 0 has top priority first.
  - FSM=IDLE and all counters are 0.
- **Grant edge:** the edge sampling `i_req`≠0 in IDLE. On that edge, registered `o_tx` falls, `o_busy` rises, and `o_ack[g]` rises. `o_ack[g]` falls one cycle later.
- **Frame length:** 10·`CLKS_PER_BIT` cycles (11· with parity). After that, `o_busy` falls and the FSM spends at least 1 IDLE cycle. Back-to-back frames therefore repeat every 10·`CLKS_PER_BIT`+1 cycles.
- **Simultaneous requests:** exactly one requester is granted per frame, in round-robin order.
- **Reset mid-frame:** the frame is abandoned. `o_tx` returns to 1 asynchronously and no `o_ack` is issued.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- **Defined:**
  - PARITY state is present; the frame is 8E1.
  - The parity bit is the XOR of the 8 data bits, sent after bit 7 for `CLKS_PER_BIT` cycles.
- **Undefined:** the PARITY state is compiled out and the frame is 8N1.

## Structure
- Package `uart_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_START`, `ST_DATA`, `ST_PARITY`, `ST_STOP`);
  - `UART_DATA_BITS`=8;
  - the constants for start-bit and stop-bit levels.
- Sub-module `baud_tick`:
  - parameter `CLKS_PER_BIT`;
  - inputs `i_clk`, `i_rst_n`, `i_clr`;
  - output `o_tick`, a one-cycle pulse every `CLKS_PER_BIT` cycles after `i_clr`.
- The arbiter, FSM and shift register stay in `uart_tx_arbiter`.

## Test plan
The bench uses `CLKS_PER_BIT`=4 and `N_REQ`=4.
- **Single byte:** req[2] with 0xA5 → `o_ack`=0100 for one cycle; `o_grant_id`=2; `o_tx` reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; `o_busy` high for 40 cycles.
- **All four requesting from reset**, bytes 0x11/0x22/0x33/0x44, each held until acked → frames sent in order 0,1,2,3; each grant is 41 cycles after the previous one.
- **Round-robin:** after a grant to 1, assert req[0] and req[3] together → grant goes to 3, then 0.
- **Withdrawal:** req[1] is asserted during a frame and dropped before the frame ends → no ack to 1 and no frame for it.
- **Reset mid-frame:** assert `i_rst_n`=0 during DATA bit 3 → `o_tx`=1 before the next edge; no ack; after release, requester 0 has priority.
- **Parity** (`UART_TX_PARITY_EN` defined): 0x07 → parity bit 1 after bit 7; frame is 44 cycles.
